// File: rtl/lipsi_program_loader.sv
// lipsi_program_loader: writes a framed byte stream (SYNC, LEN, N data, CHK)
// into the Lipsi 256x8 instruction memory. It pads addresses N..255 with the
// halt opcode and keeps the processor in reset until a frame has been written
// and its checksum verified.
// Optional feature macro: LOADER_TIMEOUT_EN adds an inter-byte timeout that
// aborts a frame stuck in LEN, DATA or CHK.
module lipsi_program_loader #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter logic [7:0] FILL_BYTE      = 8'hFF,
    parameter int         TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       cpu_hold,
    output logic       load_done,
    output logic       load_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_CHK, S_FILL, S_DONE, S_ERR
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] chk_reg, chk_next;
    logic [8:0] cnt_reg, cnt_next;      // 9 bits so a 256-byte frame is representable
    logic [8:0] len_reg, len_next;
    logic       wr_en_reg, wr_en_next;
    logic [7:0] wr_addr_reg, wr_addr_next;
    logic [7:0] wr_data_reg, wr_data_next;
    logic       hold_reg, hold_next;
    logic       done_reg, done_next;
    logic       err_reg, err_next;
    logic       accept;
    logic       is_sync;
    logic [7:0] chk_sum;

    // The stream is stalled only while padding, and while reset is held.
    assign in_ready = !reset && (state_reg != S_FILL);
    assign accept   = in_valid && in_ready;
    assign is_sync  = (in_data == SYNC_BYTE);
    assign chk_sum  = chk_reg + in_data;

`ifdef LOADER_TIMEOUT_EN
    logic [31:0] timer_reg, timer_next;
    logic        timer_active;
    logic        timed_out;

    assign timer_active = (state_reg == S_LEN) || (state_reg == S_DATA) || (state_reg == S_CHK);
    assign timed_out    = timer_active && !accept && (timer_reg == 32'(TIMEOUT_CYCLES - 1));

    // Idle-cycle counter: restarts on every accepted byte, runs only mid-frame.
    always_comb begin
        timer_next = 32'd0;
        if (!accept && timer_active) begin
            timer_next = timer_reg + 32'd1;
        end
    end

    // Timer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_reg <= 32'd0;
        end else begin
            timer_reg <= timer_next;
        end
    end
`else
    logic timed_out;
    assign timed_out = 1'b0;
`endif

    // Next-state, datapath and registered-output logic of the frame parser.
    always_comb begin
        state_next   = state_reg;
        chk_next     = chk_reg;
        cnt_next     = cnt_reg;
        len_next     = len_reg;
        wr_en_next   = 1'b0;
        wr_addr_next = wr_addr_reg;
        wr_data_next = wr_data_reg;
        hold_next    = hold_reg;
        done_next    = done_reg;
        err_next     = err_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept && is_sync) begin
                    state_next = S_LEN;
                    hold_next  = 1'b1;
                    done_next  = 1'b0;
                    err_next   = 1'b0;
                end
            end
            S_LEN: begin
                if (accept) begin
                    len_next   = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                    chk_next   = in_data;
                    cnt_next   = 9'd0;
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    wr_en_next   = 1'b1;
                    wr_addr_next = cnt_reg[7:0];
                    wr_data_next = in_data;
                    chk_next     = chk_sum;
                    cnt_next     = cnt_reg + 9'd1;
                    if (cnt_reg + 9'd1 == len_reg) begin
                        state_next = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (accept) begin
                    if (chk_sum == 8'd0) begin
                        // cnt_reg already equals N, the first pad address.
                        state_next = (len_reg == 9'd256) ? S_DONE : S_FILL;
                    end else begin
                        state_next = S_ERR;
                        err_next   = 1'b1;
                        hold_next  = 1'b1;
                    end
                end
            end
            S_FILL: begin
                wr_en_next   = 1'b1;
                wr_addr_next = cnt_reg[7:0];
                wr_data_next = FILL_BYTE;
                cnt_next     = cnt_reg + 9'd1;
                if (cnt_reg == 9'd255) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (accept && is_sync) begin
                    state_next = S_LEN;
                    hold_next  = 1'b1;
                    done_next  = 1'b0;
                end else begin
                    // Flags follow the final write by one cycle.
                    done_next = 1'b1;
                    hold_next = 1'b0;
                end
            end
            S_ERR: begin
                if (accept && is_sync) begin
                    state_next = S_LEN;
                    err_next   = 1'b0;
                end else begin
                    err_next  = 1'b1;
                    hold_next = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (timed_out) begin
            state_next = S_ERR;
            err_next   = 1'b1;
            hold_next  = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            chk_reg     <= 8'd0;
            cnt_reg     <= 9'd0;
            len_reg     <= 9'd0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= 8'd0;
            wr_data_reg <= 8'd0;
            hold_reg    <= 1'b1;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            chk_reg     <= chk_next;
            cnt_reg     <= cnt_next;
            len_reg     <= len_next;
            wr_en_reg   <= wr_en_next;
            wr_addr_reg <= wr_addr_next;
            wr_data_reg <= wr_data_next;
            hold_reg    <= hold_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
        end
    end

    assign wr_en     = wr_en_reg;
    assign wr_addr   = wr_addr_reg;
    assign wr_data   = wr_data_reg;
    assign cpu_hold  = hold_reg;
    assign load_done = done_reg;
    assign load_err  = err_reg;

endmodule

// File: tb/tb_lipsi_program_loader.sv
// Self-checking bench for lipsi_program_loader: a frame-level model turns every
// accepted byte into the list of memory writes and final flags it must cause,
// and a monitor checks every write strobe against that list.
module tb_lipsi_program_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       cpu_hold;
    logic       load_done;
    logic       load_err;

    lipsi_program_loader dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Frame-level model state.
    bit         in_frame;
    logic [7:0] frame[$];
    logic [7:0] exp_a[$];
    logic [7:0] exp_d[$];
    bit         exp_f[$];
    bit         m_done, m_err;
    bit         fill_active;

    // Memory image and write count observed on the write port.
    logic [7:0] mem_seen [256];
    int         wr_count;
    logic [7:0] tx[$];

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic void push_wr(input int a, input logic [7:0] d, input bit f);
        exp_a.push_back(8'(a));
        exp_d.push_back(d);
        exp_f.push_back(f);
    endfunction

    function automatic void model_reset();
        in_frame = 0; frame.delete();
        exp_a.delete(); exp_d.delete(); exp_f.delete();
        m_done = 0; m_err = 0; fill_active = 0;
    endfunction

    // Applies one accepted byte to the frame model.
    function automatic void model_accept(input logic [7:0] b);
        int n;
        int s;
        if (!in_frame) begin
            if (b == 8'hA5) begin
                in_frame = 1; frame.delete(); m_done = 0; m_err = 0;
            end
        end else begin
            frame.push_back(b);
            n = (frame[0] == 8'd0) ? 256 : int'(frame[0]);
            if (frame.size() >= 2 && frame.size() <= n + 1) begin
                push_wr(frame.size() - 2, b, 0);
            end else if (frame.size() == n + 2) begin
                s = 0;
                foreach (frame[i]) s += int'(frame[i]);
                if (s % 256 == 0) begin
                    for (int a = n; a < 256; a++) push_wr(a, 8'hFF, 1);
                    m_done = 1;
                end else begin
                    m_err = 1;
                end
                in_frame = 0;
            end
        end
    endfunction

    // Write-port monitor: every strobe must match the next expected write.
    always @(posedge clk) begin
        #1;
        if (wr_en) begin
            if (exp_a.size() == 0) begin
                check(0, "unexpected_write", {16'd0, wr_addr, wr_data}, 32'd0);
            end else begin
                check(wr_addr === exp_a[0] && wr_data === exp_d[0], "write_addr_data",
                      {16'd0, wr_addr, wr_data}, {16'd0, exp_a[0], exp_d[0]});
                fill_active = exp_f[0];
                void'(exp_a.pop_front()); void'(exp_d.pop_front()); void'(exp_f.pop_front());
                if (fill_active && exp_a.size() != 0)
                    check(in_ready === 1'b0, "ready_low_in_fill", 32'(in_ready), 32'd0);
                if (exp_a.size() == 0) fill_active = 0;
            end
            mem_seen[wr_addr] = wr_data;
            wr_count++;
        end else if (fill_active) begin
            check(0, "fill_gap", {24'd0, exp_a[0]}, 32'd1);
            fill_active = 0;
        end
        check(cpu_hold === !load_done && !(load_done && load_err), "flag_consistency",
              {29'd0, cpu_hold, load_done, load_err}, {29'd0, !load_done, load_done, 1'b0});
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int w;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        w = 0;
        while (!in_ready && w < 600) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            check(0, "ready_timeout", 32'(w), 32'd0);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_accept(b);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // gap_mode: 0 back-to-back, 1 one idle cycle per byte, 2 random idles.
    task automatic send_list(input int gap_mode);
        foreach (tx[i]) send_byte(tx[i], gap_mode == 0 ? 0 : gap_mode == 1 ? 1 : int'($urandom_range(0, 2)));
    endtask

    task automatic settle(input string tag);
        int w = 0;
        while (exp_a.size() != 0 && w < 600) begin
            @(posedge clk);
            w++;
        end
        check(exp_a.size() == 0, {tag, "_writes_drained"}, 32'(exp_a.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check(load_done === m_done, {tag, "_load_done"}, 32'(load_done), 32'(m_done));
        check(load_err === m_err, {tag, "_load_err"}, 32'(load_err), 32'(m_err));
        check(cpu_hold === !m_done, {tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!m_done));
        @(negedge clk);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check(in_ready === 1'b0, {tag, "_ready_in_reset"}, 32'(in_ready), 32'd0);
        @(posedge clk);
        model_reset();
        #1;
        check(wr_en === 1'b0 && wr_addr === 8'd0 && wr_data === 8'd0, {tag, "_wr_port_reset"},
              {15'd0, wr_en, wr_addr, wr_data}, 32'd0);
        check(cpu_hold === 1'b1 && load_done === 1'b0 && load_err === 1'b0, {tag, "_flags_reset"},
              {29'd0, cpu_hold, load_done, load_err}, 32'd4);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check(in_ready === 1'b1, {tag, "_ready_after_reset"}, 32'(in_ready), 32'd1);
    endtask

    task automatic load_test1_frame(input int gap_mode);
        tx = '{8'hA5, 8'h03, 8'hC7, 8'h0F, 8'h81, 8'hA6};
        send_list(gap_mode);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, n, s;
        bit corrupt;
        reset = 1'b1; in_valid = 1'b0; in_data = 8'd0;
        model_reset();
        wr_count = 0;
        repeat (2) @(negedge clk);
        apply_reset("t0");

        // Test 1: three data bytes, then pad 3..255.
        wr_count = 0;
        load_test1_frame(0);
        settle("t1");
        check(wr_count == 256, "t1_write_count", 32'(wr_count), 32'd256);
        check(mem_seen[0] == 8'hC7 && mem_seen[1] == 8'h0F && mem_seen[2] == 8'h81, "t1_data_words",
              {8'd0, mem_seen[0], mem_seen[1], mem_seen[2]}, 32'h00C70F81);
        check(mem_seen[3] == 8'hFF && mem_seen[255] == 8'hFF, "t1_pad_words",
              {16'd0, mem_seen[3], mem_seen[255]}, 32'h0000FFFF);
        check(load_done === 1'b1 && cpu_hold === 1'b0, "t1_literal_done",
              {30'd0, load_done, cpu_hold}, 32'd2);

        // Test 2: bad checksum.
        wr_count = 0;
        tx = '{8'hA5, 8'h03, 8'hC7, 8'h0F, 8'h81, 8'hA7};
        send_list(0);
        settle("t2");
        check(wr_count == 3, "t2_write_count", 32'(wr_count), 32'd3);
        check(load_err === 1'b1 && cpu_hold === 1'b1 && load_done === 1'b0, "t2_literal_err",
              {29'd0, load_err, cpu_hold, load_done}, 32'd6);

        // Test 3: junk from ERR is ignored, then a good frame.
        wr_count = 0;
        tx = '{8'h00, 8'h11};
        send_list(0);
        settle("t3a");
        check(wr_count == 0, "t3_junk_no_writes", 32'(wr_count), 32'd0);
        load_test1_frame(0);
        settle("t3b");
        check(wr_count == 256 && mem_seen[2] == 8'h81, "t3_reload", {16'(wr_count), 8'd0, mem_seen[2]}, 32'h01000081);

        // Test 4: LEN=0 means 256 data bytes, no padding.
        wr_count = 0;
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 256; i++) send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        settle("t4");
        check(wr_count == 256 && mem_seen[0] == 8'h01 && mem_seen[255] == 8'h01, "t4_full_frame",
              {16'(wr_count), mem_seen[0], mem_seen[255]}, 32'h01000101);
        check(load_done === 1'b1, "t4_literal_done", 32'(load_done), 32'd1);

        // Test 5: toggling valid, reset after the second data byte, then a clean load.
        tx = '{8'hA5, 8'h03, 8'hC7, 8'h0F};
        send_list(1);
        apply_reset("t5");
        wr_count = 0;
        load_test1_frame(1);
        settle("t5");
        check(wr_count == 256, "t5_write_count", 32'(wr_count), 32'd256);

`ifdef LOADER_TIMEOUT_EN
        // Test 6: stall mid-frame until the timeout fires.
        wr_count = 0;
        tx = '{8'hA5, 8'h03, 8'hC7};
        send_list(0);
        repeat (990) @(posedge clk);
        #1;
        check(load_err === 1'b0, "t6_no_early_timeout", 32'(load_err), 32'd0);
        repeat (12) @(posedge clk);
        #1;
        in_frame = 0; m_err = 1;
        check(load_err === 1'b1 && cpu_hold === 1'b1, "t6_timeout_err", {30'd0, load_err, cpu_hold}, 32'd3);
        check(wr_count == 1, "t6_writes", 32'(wr_count), 32'd1);
        @(negedge clk);
        send_byte(8'hA5, 0);
        settle("t6_resync");
        tx = '{8'h03, 8'hC7, 8'h0F, 8'h81, 8'hA6};
        send_list(0);
        settle("t6_reload");
`endif

        // Randomised frames with junk, random gaps and occasional corruption.
        for (int f = 0; f < 20; f++) begin
            tx.delete();
            for (int j = 0; j < int'($urandom_range(0, 2)); j++)
                tx.push_back(8'($urandom_range(0, 163)));
            len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
            n = (len == 0) ? 256 : len;
            tx.push_back(8'hA5);
            tx.push_back(8'(len));
            s = len;
            for (int j = 0; j < n; j++) begin
                tx.push_back(8'($urandom_range(0, 255)));
                s += int'(tx[tx.size() - 1]);
            end
            corrupt = ($urandom_range(0, 3) == 0);
            tx.push_back(8'((256 - (s % 256)) + (corrupt ? int'($urandom_range(1, 255)) : 0)));
            send_list(($urandom_range(0, 2) == 0) ? 0 : 2);
            settle("rand");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
